// File: rtl/gate_test_sequencer.sv
// Exhaustive 2-input gate tester: applies vectors 00..11, compares dut_y to TRUTH, reports errors.
// Optional macro GTS_FIRST_FAIL_EN enables capture of the first mismatching vector index.
module gate_test_sequencer #(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter logic [3:0]  TRUTH         = 4'b1110
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       dut_a,
  output logic       dut_b,
  input  logic       dut_y,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_count,
  output logic [1:0] first_fail_vec,
  output logic       first_fail_valid
);

  typedef enum logic [1:0] {ST_IDLE, ST_APPLY, ST_SAMPLE, ST_DONE} state_t;

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

  state_t     r_state, w_next_state;
  logic [1:0] r_vec, w_vec_nxt;
  logic [3:0] r_settle, w_settle_nxt;
  logic [2:0] r_err, w_err_nxt;
  logic       r_pass, w_pass_nxt;
  logic       r_busy, r_done, r_a, r_b;
  logic       w_accept, w_mismatch, w_drive;

  assign w_accept   = (r_state == ST_IDLE) && start;
  assign w_mismatch = (r_state == ST_SAMPLE) && (dut_y != TRUTH[r_vec]);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_vec    <= 2'd0;
      r_settle <= 4'd0;
      r_err    <= 3'd0;
      r_pass   <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_a      <= 1'b0;
      r_b      <= 1'b0;
    end else begin
      r_state  <= w_next_state;
      r_vec    <= w_vec_nxt;
      r_settle <= w_settle_nxt;
      r_err    <= w_err_nxt;
      r_pass   <= w_pass_nxt;
      r_busy   <= (w_next_state != ST_IDLE);
      r_done   <= (w_next_state == ST_DONE);
      r_a      <= w_drive & w_vec_nxt[1];
      r_b      <= w_drive & w_vec_nxt[0];
    end
  end

  // NOTE: every always_comb output gets a default first so no latch can be inferred.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:   if (start) w_next_state = ST_APPLY;
      ST_APPLY:  if (r_settle == SETTLE_LAST) w_next_state = ST_SAMPLE;
      ST_SAMPLE: w_next_state = (r_vec == 2'd3) ? ST_DONE : ST_APPLY;
      ST_DONE:   w_next_state = ST_IDLE;
      default:   w_next_state = ST_IDLE;
    endcase
  end

  // Next values of the registered outputs and datapath, derived from the next state.
  always_comb begin
    w_vec_nxt    = r_vec;
    w_settle_nxt = 4'd0;
    w_err_nxt    = r_err;
    w_pass_nxt   = r_pass;
    w_drive      = (w_next_state == ST_APPLY) || (w_next_state == ST_SAMPLE);
    if (w_accept) begin
      w_vec_nxt  = 2'd0;
      w_err_nxt  = 3'd0;
      w_pass_nxt = 1'b0;
    end
    if (r_state == ST_APPLY && r_settle != SETTLE_LAST)
      w_settle_nxt = r_settle + 4'd1;
    if (w_mismatch && r_err < 3'd4)
      w_err_nxt = r_err + 3'd1;
    if (r_state == ST_SAMPLE) begin
      if (r_vec != 2'd3) w_vec_nxt = r_vec + 2'd1;
      else               w_pass_nxt = (w_err_nxt == 3'd0);
    end
  end

  assign dut_a     = r_a;
  assign dut_b     = r_b;
  assign busy      = r_busy;
  assign done      = r_done;
  assign pass      = r_pass;
  assign err_count = r_err;

`ifdef GTS_FIRST_FAIL_EN
  logic [1:0] r_ff_vec;
  logic       r_ff_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ff_vec   <= 2'd0;
      r_ff_valid <= 1'b0;
    end else if (w_accept) begin
      r_ff_valid <= 1'b0;
    end else if (w_mismatch && !r_ff_valid) begin
      r_ff_vec   <= r_vec;
      r_ff_valid <= 1'b1;
    end
  end

  assign first_fail_vec   = r_ff_vec;
  assign first_fail_valid = r_ff_valid;
`else
  assign first_fail_vec   = 2'd0;
  assign first_fail_valid = 1'b0;
`endif

endmodule

// File: tb/tb_gate_test_sequencer.sv
// Directed bench for gate_test_sequencer: behavioural gate models on dut_y, scoreboard of run results.
module tb_gate_test_sequencer;

  localparam int         SETTLE  = 2;
  localparam logic [3:0] TRUTH_T = 4'b1110;
  localparam int         LAT     = 4 * (SETTLE + 1);

  typedef enum int {M_OR, M_STUCK0, M_STUCK1, M_AND} mode_t;

  typedef struct {
    logic [2:0] err;
    logic       pass;
    logic [1:0] ffv;
    logic       ffvalid;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       dut_a, dut_b, dut_y;
  logic       busy, done, pass;
  logic [2:0] err_count;
  logic [1:0] first_fail_vec;
  logic       first_fail_valid;
  mode_t      mode = M_OR;

  int   checks = 0;
  int   failures = 0;
  exp_t sb[$];

  gate_test_sequencer #(.SETTLE_CYCLES(SETTLE), .TRUTH(TRUTH_T)) u_dut (
    .clk              (clk),
    .rst              (rst),
    .start            (start),
    .dut_a            (dut_a),
    .dut_b            (dut_b),
    .dut_y            (dut_y),
    .busy             (busy),
    .done             (done),
    .pass             (pass),
    .err_count        (err_count),
    .first_fail_vec   (first_fail_vec),
    .first_fail_valid (first_fail_valid)
  );

  always #5 clk = ~clk;

  function automatic logic gate(input mode_t m, input logic a, input logic b);
    case (m)
      M_OR:     return a | b;
      M_STUCK0: return 1'b0;
      M_STUCK1: return 1'b1;
      default:  return a & b;
    endcase
  endfunction

  assign dut_y = gate(mode, dut_a, dut_b);

  function automatic exp_t predict(input mode_t m);
    exp_t e;
    logic [1:0] v;
    e = '{err: 3'd0, pass: 1'b0, ffv: 2'd0, ffvalid: 1'b0};
    for (int i = 0; i < 4; i++) begin
      v = 2'(i);
      if (gate(m, v[1], v[0]) != TRUTH_T[i]) begin
`ifdef GTS_FIRST_FAIL_EN
        if (!e.ffvalid) begin
          e.ffv     = v;
          e.ffvalid = 1'b1;
        end
`endif
        e.err = e.err + 3'd1;
      end
    end
    e.pass = (e.err == 3'd0);
    return e;
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_outs"}, {dut_a, dut_b, busy, done, pass, first_fail_valid, 2'b00}, 8'h00);
    check({tag, "_err"}, 8'(err_count), 8'h00);
    check({tag, "_ffv"}, 8'(first_fail_vec), 8'h00);
  endtask

  task automatic check_results(input string tag, input exp_t e);
    check({tag, "_err"}, 8'(err_count), 8'(e.err));
    check({tag, "_pass"}, 8'(pass), 8'(e.pass));
    check({tag, "_ffv"}, 8'(first_fail_vec), 8'(e.ffv));
    check({tag, "_ffvalid"}, 8'(first_fail_valid), 8'(e.ffvalid));
  endtask

  // One full run: drives start, tracks vectors cycle by cycle, pops the scoreboard on done.
  task automatic run(input mode_t m, input bit repulse, input string tag);
    int   c;
    int   bad_vec;
    int   bad_busy;
    logic [1:0] idx;
    exp_t e;
    mode = m;
    @(negedge clk);
    start = 1'b1;
    sb.push_back(predict(m));
    @(negedge clk);
    start = 1'b0;
    c = 0;
    bad_vec = 0;
    bad_busy = 0;
    while (!done && c < 40) begin
      if (c < LAT) begin
        idx = 2'(c / (SETTLE + 1));
        if (dut_a !== idx[1] || dut_b !== idx[0]) bad_vec++;
        if (busy !== 1'b1) bad_busy++;
      end
      start = (repulse && c == 4);
      c++;
      @(negedge clk);
    end
    start = 1'b0;
    check({tag, "_vectors"}, 8'(bad_vec), 8'd0);
    check({tag, "_busy_run"}, 8'(bad_busy), 8'd0);
    check({tag, "_latency"}, 8'(c), 8'(LAT));
    check({tag, "_done"}, {7'd0, done}, 8'd1);
    check({tag, "_busy_done"}, {7'd0, busy}, 8'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check_results(tag, e);
      @(negedge clk);
      check({tag, "_idle"}, {4'd0, done, busy, dut_a, dut_b}, 8'd0);
      repeat (3) @(negedge clk);
      check_results({tag, "_hold"}, e);
    end
  endtask

  initial begin : stim
    int dones;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    @(negedge clk);
    check_all_zero("idle");

    run(M_OR,     1'b0, "or");
    run(M_STUCK0, 1'b0, "stuck0");
    run(M_STUCK1, 1'b0, "stuck1");
    run(M_AND,    1'b0, "and");
    run(M_OR,     1'b1, "repulse");

    // Abort a run in the APPLY phase of vector 2.
    mode = M_STUCK0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    check("abort_vec2", {6'd0, dut_a, dut_b}, 8'b10);
    rst   = 1'b1;
    start = 1'b1;
    @(negedge clk);
    check_all_zero("abort");
    rst   = 1'b0;
    start = 1'b0;
    dones = 0;
    repeat (20) begin
      @(negedge clk);
      if (done) dones++;
    end
    check("abort_no_done", 8'(dones), 8'd0);

    run(M_OR, 1'b0, "after_abort");
    check("sb_empty", 8'(sb.size()), 8'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
